// File: rtl/stage_ma_access_pkg.sv
// ============================================================
// ma_pkg : shared types for the memory-access stage
// Revision: 1.0
// ============================================================
`default_nettype none

package ma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_REQ   = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_REQ   = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_DONE     = 3'd5,
    ST_DRAIN    = 3'd6
  } ma_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int         SZ_UNSIGNED = 2;

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_SWAP = 4'd1,
    AMO_ADD  = 4'd2,
    AMO_XOR  = 4'd3,
    AMO_AND  = 4'd4,
    AMO_OR   = 4'd5,
    AMO_MIN  = 4'd6,
    AMO_MAX  = 4'd7,
    AMO_MINU = 4'd8,
    AMO_MAXU = 4'd9
  } amo_op_t;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       lr;
    logic       sc;
    amo_op_t    amo;
    logic [2:0] size;
    logic [7:0] mask;
  } io_ops_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_ma_access_if.sv
// ============================================================
// stage_ma_access_if : data-bus request/response channel
// Revision: 1.0
// ============================================================
`default_nettype none

interface stage_ma_access_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/stage_ma_access_amo_alu.sv
// ============================================================
// amo_alu : combinational read-modify-write operator for AMOs
// Revision: 1.0
// ============================================================
`default_nettype none

module amo_alu
  import ma_pkg::*;
(
  input  amo_op_t     op,
  input  logic        is_word,
  input  logic [63:0] old_val,
  input  logic [63:0] rs2,
  output logic [63:0] new_val
);

  logic [63:0] w_a_s, w_b_s, w_a_u, w_b_u, w_res;
  logic        w_lt_s, w_lt_u;

  // word ops compare on the low 32 bits with the appropriate extension
  assign w_a_s  = is_word ? sext32(old_val[31:0]) : old_val;
  assign w_b_s  = is_word ? sext32(rs2[31:0])     : rs2;
  assign w_a_u  = is_word ? {32'd0, old_val[31:0]} : old_val;
  assign w_b_u  = is_word ? {32'd0, rs2[31:0]}     : rs2;
  assign w_lt_s = $signed(w_a_s) < $signed(w_b_s);
  assign w_lt_u = w_a_u < w_b_u;

  always_comb begin
    w_res = old_val;
    case (op)
      AMO_SWAP: w_res = rs2;
      AMO_ADD:  w_res = old_val + rs2;
      AMO_XOR:  w_res = old_val ^ rs2;
      AMO_AND:  w_res = old_val & rs2;
      AMO_OR:   w_res = old_val | rs2;
      AMO_MIN:  w_res = w_lt_s ? old_val : rs2;
      AMO_MAX:  w_res = w_lt_s ? rs2 : old_val;
      AMO_MINU: w_res = w_lt_u ? old_val : rs2;
      AMO_MAXU: w_res = w_lt_u ? rs2 : old_val;
      default:  w_res = old_val;
    endcase
  end

  assign new_val = is_word ? sext32(w_res[31:0]) : w_res;

endmodule

`default_nettype wire

// File: rtl/stage_ma_access.sv
// ============================================================
// stage_ma_access : MA-stage engine for load/store/LR/SC/AMO,
//                   stalls the pipe until the bus op completes
// Revision: 1.0
// ============================================================
`default_nettype none

module stage_ma_access
  import ma_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int RSV_GRAN = 3
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            clear,
  input  wire logic [XLEN-1:0] pc_in,
  input  wire logic [4:0]      rd_in,
  input  wire logic [63:0]     addr_in,
  input  wire logic [63:0]     data2_in,
  input  wire io_ops_t         io_ops_in,
  stage_ma_access_if.master    mem,
  output logic                 stall_out,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [63:0]          wb_data
);

  ma_state_t r_state, w_next;

  logic                 r_rsv_valid;
  logic [63-RSV_GRAN:0] r_rsv_addr;
  logic [63:0]          r_result;

  logic        w_is_amo, w_mem_op, w_rd_op, w_rsv_hit;
  logic        w_req_valid, w_req_write, w_wb_valid;
  logic [5:0]  w_shift;
  logic [63:0] w_lane, w_loaded, w_amo_old, w_amo_new, w_wr_src;
  logic        w_unused_pc;

  assign w_unused_pc = ^pc_in;

  assign w_is_amo  = (io_ops_in.amo != AMO_NONE);
  assign w_mem_op  = io_ops_in.load | io_ops_in.store | io_ops_in.lr | io_ops_in.sc | w_is_amo;
  assign w_rd_op   = io_ops_in.load | io_ops_in.lr | w_is_amo;
  assign w_rsv_hit = r_rsv_valid && (addr_in[63:RSV_GRAN] == r_rsv_addr);
  assign w_shift   = {addr_in[2:0], 3'b000};
  assign w_lane    = mem.mem_rsp_rdata >> w_shift;

  always_comb begin
    w_loaded = w_lane;
    case (io_ops_in.size[1:0])
      SZ_B: w_loaded = io_ops_in.size[SZ_UNSIGNED] ? {56'd0, w_lane[7:0]}
                                                   : {{56{w_lane[7]}}, w_lane[7:0]};
      SZ_H: w_loaded = io_ops_in.size[SZ_UNSIGNED] ? {48'd0, w_lane[15:0]}
                                                   : {{48{w_lane[15]}}, w_lane[15:0]};
      SZ_W: w_loaded = io_ops_in.size[SZ_UNSIGNED] ? {32'd0, w_lane[31:0]}
                                                   : sext32(w_lane[31:0]);
      default: w_loaded = w_lane;
    endcase
  end

  // AMO old value is always sign-extended, regardless of the unsigned bit
  assign w_amo_old = (io_ops_in.size[1:0] == SZ_W) ? sext32(w_lane[31:0]) : w_lane;

  amo_alu u_amo_alu (
    .op      (io_ops_in.amo),
    .is_word (io_ops_in.size[1:0] == SZ_W),
    .old_val (r_result),
    .rs2     (data2_in),
    .new_val (w_amo_new)
  );

  assign w_wr_src = w_is_amo ? w_amo_new : data2_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_valid = 1'b0;
    w_req_write = 1'b0;
    w_wb_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!clear && w_mem_op) begin
          if (w_rd_op)              w_next = ST_RD_REQ;
          else if (io_ops_in.store) w_next = ST_WR_REQ;
          else                      w_next = w_rsv_hit ? ST_WR_REQ : ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (clear) begin
          w_next = ST_IDLE;
        end else begin
          w_req_valid = 1'b1;
          if (mem.mem_req_ready) w_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // a response arriving with clear needs no drain
        if (clear)                  w_next = mem.mem_rsp_valid ? ST_IDLE : ST_DRAIN;
        else if (mem.mem_rsp_valid) w_next = w_is_amo ? ST_WR_REQ : ST_DONE;
      end
      ST_WR_REQ: begin
        if (clear) begin
          w_next = ST_IDLE;
        end else begin
          w_req_valid = 1'b1;
          w_req_write = 1'b1;
          if (mem.mem_req_ready) w_next = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (clear)                  w_next = mem.mem_rsp_valid ? ST_IDLE : ST_DRAIN;
        else if (mem.mem_rsp_valid) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next     = ST_IDLE;
        w_wb_valid = !clear && !io_ops_in.store;
      end
      ST_DRAIN: begin
        if (mem.mem_rsp_valid) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsv_valid <= 1'b0;
      r_rsv_addr  <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!clear && io_ops_in.sc && !w_rd_op && !io_ops_in.store) begin
            r_rsv_valid <= 1'b0;
            if (!w_rsv_hit) r_result <= 64'd1;
          end
        end
        ST_RD_WAIT: begin
          if (!clear && mem.mem_rsp_valid) begin
            r_result <= w_is_amo ? w_amo_old : w_loaded;
            if (io_ops_in.lr) begin
              r_rsv_valid <= 1'b1;
              r_rsv_addr  <= addr_in[63:RSV_GRAN];
            end
          end
        end
        ST_WR_WAIT: begin
          if (!clear && mem.mem_rsp_valid && io_ops_in.sc) r_result <= 64'd0;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req_valid = w_req_valid;
  assign mem.mem_req_write = w_req_write;
  assign mem.mem_req_addr  = w_req_valid ? {addr_in[63:3], 3'b000} : 64'd0;
  assign mem.mem_req_wdata = w_req_write ? (w_wr_src << w_shift) : 64'd0;
  assign mem.mem_req_wmask = w_req_write ? (io_ops_in.mask << addr_in[2:0]) : 8'd0;

  assign stall_out = (r_state == ST_DRAIN) || (w_mem_op && (r_state != ST_DONE));
  assign wb_valid  = w_wb_valid;
  assign wb_rd     = w_wb_valid ? rd_in : 5'd0;
  assign wb_data   = w_wb_valid ? r_result : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_stage_ma_access.sv
// ============================================================
// tb_stage_ma_access : directed + random check of the MA stage
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_stage_ma_access;
  import ma_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [63:0] pc_in, addr_in, data2_in;
  logic [4:0]  rd_in;
  io_ops_t     io_ops_in;
  logic        stall_out, wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  always #5 clk = ~clk;

  stage_ma_access_if mem_if ();

  stage_ma_access dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .pc_in     (pc_in),
    .rd_in     (rd_in),
    .addr_in   (addr_in),
    .data2_in  (data2_in),
    .io_ops_in (io_ops_in),
    .mem       (mem_if),
    .stall_out (stall_out),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // byte-addressed memories: what the bus sees, and what the model predicts
  logic [7:0] bus_mem [logic [63:0]];
  logic [7:0] ref_mem [logic [63:0]];

  function automatic logic [7:0] seed_byte(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h9E37_79B1;
    return h[31:24] ^ h[7:0];
  endfunction

  function automatic logic [7:0] bus_rd(input logic [63:0] a);
    if (!bus_mem.exists(a)) bus_mem[a] = seed_byte(a);
    return bus_mem[a];
  endfunction

  function automatic logic [7:0] ref_rd(input logic [63:0] a);
    if (!ref_mem.exists(a)) ref_mem[a] = seed_byte(a);
    return ref_mem[a];
  endfunction

  function automatic logic [63:0] bus_word(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = bus_rd({a[63:3], 3'b000} + 64'(i));
    return v;
  endfunction

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_rd({a[63:3], 3'b000} + 64'(i));
    return v;
  endfunction

  task automatic preload(input logic [63:0] a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      bus_mem[a + 64'(i)] = v[8*i +: 8];
      ref_mem[a + 64'(i)] = v[8*i +: 8];
    end
  endtask

  // ---------------- bus responder and monitor ----------------
  logic        acc = 1'b0, acc_wr = 1'b0, acc_rst = 1'b0;
  logic [63:0] acc_addr, acc_wdata;
  logic [7:0]  acc_wmask;
  int          mon_wb = 0, mon_wr = 0;
  logic [63:0] last_waddr = '0, last_wdata = '0;
  logic [7:0]  last_wmask = '0;
  logic        ready_rand = 1'b0;
  int          rsp_extra  = 0;
  int          cyc = 0;
  int          due_q [$];
  logic [63:0] rdat_q [$];

  always @(negedge clk) begin
    acc_rst   = rst;
    acc       = mem_if.mem_req_valid & mem_if.mem_req_ready;
    acc_wr    = mem_if.mem_req_write;
    acc_addr  = mem_if.mem_req_addr;
    acc_wdata = mem_if.mem_req_wdata;
    acc_wmask = mem_if.mem_req_wmask;
    if (wb_valid) mon_wb++;
    if (acc && acc_wr) begin
      mon_wr++;
      last_waddr = acc_addr;
      last_wdata = acc_wdata;
      last_wmask = acc_wmask;
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = '0;
    if (acc_rst) begin
      due_q.delete();
      rdat_q.delete();
    end else begin
      if (acc) begin
        if (acc_wr) begin
          for (int i = 0; i < 8; i++)
            if (acc_wmask[i]) bus_mem[acc_addr + 64'(i)] = acc_wdata[8*i +: 8];
          rdat_q.push_back('0);
        end else begin
          rdat_q.push_back(bus_word(acc_addr));
        end
        due_q.push_back(cyc + rsp_extra);
      end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = rdat_q.pop_front();
      end
    end
    mem_if.mem_req_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // ---------------- behavioural reference model ----------------
  logic        ref_rsv_valid = 1'b0;
  logic [63:0] ref_rsv_gran  = '0;

  function automatic io_ops_t mk(input int kind, input amo_op_t a, input logic [2:0] sz);
    io_ops_t o;
    o = '0;
    case (kind)
      0: o.load  = 1'b1;
      1: o.store = 1'b1;
      2: o.lr    = 1'b1;
      3: o.sc    = 1'b1;
      default: o.amo = a;
    endcase
    o.size = sz;
    o.mask = 8'((16'd1 << (1 << sz[1:0])) - 16'd1);
    return o;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) ref_mem[a + 64'(i)] = v[8*i +: 8];
  endtask

  task automatic model(input io_ops_t op, input logic [63:0] addr, input logic [63:0] d2,
                       output logic exp_wbv, output logic [63:0] exp_wb,
                       output int exp_wr, output int exp_lat);
    int          n;
    logic [63:0] raw, sx;
    n   = 1 << op.size[1:0];
    raw = '0;
    for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_rd(addr + 64'(i));
    sx = raw;
    if (n < 8 && raw[8*n-1]) sx = raw | (~64'd0 << (8*n));
    exp_wbv = 1'b1; exp_wb = '0; exp_wr = 0; exp_lat = 4;
    if (op.load || op.lr) begin
      exp_wb = op.size[2] ? raw : sx;
      if (op.lr) begin
        ref_rsv_valid = 1'b1;
        ref_rsv_gran  = addr >> 3;
      end
    end else if (op.store) begin
      exp_wbv = 1'b0; exp_wr = 1;
      ref_write(addr, d2, n);
    end else if (op.sc) begin
      if (ref_rsv_valid && (addr >> 3) == ref_rsv_gran) begin
        exp_wb = 64'd0; exp_wr = 1;
        ref_write(addr, d2, n);
      end else begin
        exp_wb = 64'd1; exp_lat = 2;
      end
      ref_rsv_valid = 1'b0;
    end else begin
      exp_wb = sx; exp_wr = 1; exp_lat = 6;
      if (n == 4) begin
        int a, b, r;
        int unsigned ua, ub;
        a = raw[31:0]; b = d2[31:0]; ua = raw[31:0]; ub = d2[31:0];
        case (op.amo)
          AMO_SWAP: r = b;
          AMO_ADD:  r = a + b;
          AMO_XOR:  r = a ^ b;
          AMO_AND:  r = a & b;
          AMO_OR:   r = a | b;
          AMO_MIN:  r = (a < b) ? a : b;
          AMO_MAX:  r = (a > b) ? a : b;
          AMO_MINU: r = (ua < ub) ? a : b;
          default:  r = (ua > ub) ? a : b;
        endcase
        ref_write(addr, 64'(unsigned'(r)), 4);
      end else begin
        longint a, b, r;
        longint unsigned ua, ub;
        a = raw; b = d2; ua = raw; ub = d2;
        case (op.amo)
          AMO_SWAP: r = b;
          AMO_ADD:  r = a + b;
          AMO_XOR:  r = a ^ b;
          AMO_AND:  r = a & b;
          AMO_OR:   r = a | b;
          AMO_MIN:  r = (a < b) ? a : b;
          AMO_MAX:  r = (a > b) ? a : b;
          AMO_MINU: r = (ua < ub) ? a : b;
          default:  r = (ua > ub) ? a : b;
        endcase
        ref_write(addr, r, 8);
      end
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic run_op(input string tag, input io_ops_t op, input logic [63:0] addr,
                        input logic [63:0] d2, input logic chk_lat);
    logic        exp_wbv, got_wbv, done;
    logic [63:0] exp_wb, got_wb;
    logic [4:0]  rd, got_rd;
    int          exp_wr, exp_lat, n, wr0, wb0;
    model(op, addr, d2, exp_wbv, exp_wb, exp_wr, exp_lat);
    rd        = 5'($urandom_range(1, 31));
    io_ops_in = op; addr_in = addr; data2_in = d2; rd_in = rd;
    pc_in     = {32'd0, $urandom};
    wr0 = mon_wr; wb0 = mon_wb;
    n = 0; done = 1'b0; got_wbv = 1'b0; got_wb = '0; got_rd = '0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (!stall_out) begin
        done = 1'b1; got_wbv = wb_valid; got_wb = wb_data; got_rd = wb_rd;
      end
    end
    @(posedge clk); #1;
    io_ops_in = '0;
    @(negedge clk);
    check({tag, ".strobe_len"}, 64'(wb_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, ".completed"}, 64'(done), 64'd1);
    check({tag, ".wb_valid"}, 64'(got_wbv), 64'(exp_wbv));
    if (exp_wbv) begin
      check({tag, ".wb_data"}, got_wb, exp_wb);
      check({tag, ".wb_rd"}, 64'(got_rd), 64'(rd));
    end
    check({tag, ".wb_count"}, 64'(mon_wb - wb0), 64'(exp_wbv));
    check({tag, ".writes"}, 64'(mon_wr - wr0), 64'(exp_wr));
    check({tag, ".mem"}, bus_word(addr), ref_word(addr));
    if (chk_lat) check({tag, ".latency"}, 64'(n), 64'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    io_ops_t     op;
    logic [63:0] a, d;
    int          kind, wr0, wb0, n;
    logic        drained;
    logic [2:0]  sz;

    rst = 1'b1; clear = 1'b0; io_ops_in = '0; pc_in = '0; rd_in = '0;
    addr_in = '0; data2_in = '0;
    mem_if.mem_req_ready = 1'b1; mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rsp_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.stall", 64'(stall_out), 64'd0);
    check("reset.wb_valid", 64'(wb_valid), 64'd0);
    check("reset.wb_data", wb_data, 64'd0);
    check("reset.req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    preload(64'h1000, 64'h1122_3344_5566_7788);
    run_op("ld", mk(0, AMO_NONE, 3'd3), 64'h1000, 64'd0, 1'b1);

    preload(64'h1000, 64'h0000_0000_8000_0000);
    run_op("lb", mk(0, AMO_NONE, 3'd0), 64'h1003, 64'd0, 1'b1);
    run_op("lbu", mk(0, AMO_NONE, 3'd4), 64'h1003, 64'd0, 1'b1);

    run_op("sw", mk(1, AMO_NONE, 3'd2), 64'h1004, 64'hDEAD_BEEF, 1'b1);
    check("sw.wdata_hi", {32'd0, last_wdata[63:32]}, 64'hDEAD_BEEF);
    check("sw.wmask", 64'(last_wmask), 64'hF0);
    check("sw.waddr", last_waddr, 64'h1000);

    preload(64'h2000, 64'h0000_0000_7FFF_FFFF);
    run_op("amoadd_w", mk(4, AMO_ADD, 3'd2), 64'h2000, 64'd1, 1'b1);
    check("amoadd_w.wdata_lo", {32'd0, last_wdata[31:0]}, 64'h8000_0000);

    run_op("lr_d", mk(2, AMO_NONE, 3'd3), 64'h3000, 64'd0, 1'b1);
    run_op("sc_d_pass", mk(3, AMO_NONE, 3'd3), 64'h3000, 64'h0123_4567_89AB_CDEF, 1'b1);
    run_op("sc_d_fail", mk(3, AMO_NONE, 3'd3), 64'h3000, 64'hFFFF_0000_FFFF_0000, 1'b1);

    // AMO killed while its read is outstanding
    rsp_extra = 3;
    preload(64'h2100, 64'hCAFE_F00D_1234_5678);
    wr0 = mon_wr; wb0 = mon_wb;
    io_ops_in = mk(4, AMO_SWAP, 3'd3); addr_in = 64'h2100; data2_in = 64'h5555_AAAA_5555_AAAA;
    rd_in = 5'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1; io_ops_in = '0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear.drain_stall", 64'(stall_out), 64'd1);
    drained = 1'b0; n = 0;
    while (!drained && n < 20) begin
      @(negedge clk);
      n++;
      if (!stall_out) drained = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("clear.drained", 64'(drained), 64'd1);
    check("clear.no_write", 64'(mon_wr - wr0), 64'd0);
    check("clear.no_wb", 64'(mon_wb - wb0), 64'd0);
    check("clear.mem", bus_word(64'h2100), 64'hCAFE_F00D_1234_5678);
    rsp_extra = 0;
    run_op("after_clear_ld", mk(0, AMO_NONE, 3'd3), 64'h2100, 64'd0, 1'b1);

    // random traffic with back-pressure and variable response delay
    ready_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      if (kind >= 2) sz = 3'($urandom_range(2, 3));
      else           sz = {(kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0, 2'($urandom_range(0, 3))};
      a = 64'h1000 + 64'($urandom_range(0, (kind >= 2) ? 3 : 15) * 8);
      a = a + 64'($urandom_range(0, (8 >> sz[1:0]) - 1) * (1 << sz[1:0]));
      d = {$urandom, $urandom};
      rsp_extra = $urandom_range(0, 2);
      run_op($sformatf("rnd%0d", t), mk(kind, amo_op_t'($urandom_range(1, 9)), sz), a, d, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
